// File: rtl/mma_icb_pkg.sv
// rtl/mma_icb_pkg.sv - MMA ICB requester ids and bus widths
package mma_icb_pkg;

  localparam int NUM_MMA_REQ    = 5;
  localparam int ICB_ADDR_WIDTH = 32;
  localparam int ICB_DATA_WIDTH = 32;
  localparam int REQ_ID_W       = $clog2(NUM_MMA_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  localparam req_id_t REQ_WEIGHT = 3'd0;
  localparam req_id_t REQ_BIAS   = 3'd1;
  localparam req_id_t REQ_IA     = 3'd2;
  localparam req_id_t REQ_QPARAM = 3'd3;
  localparam req_id_t REQ_DST    = 3'd4;

endpackage

// File: rtl/icb_tag_fifo.sv
// rtl/icb_tag_fifo.sv - in-order FIFO of requester ids for outstanding ICB commands
module icb_tag_fifo
  import mma_icb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = $bits(req_id_t),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [ID_W-1:0]  i_push_id,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [ID_W-1:0]  o_head
);

  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_id;
  end

endmodule

// File: rtl/mma_icb_arbiter.sv
// rtl/mma_icb_arbiter.sv - round-robin ICB arbiter with grant lock and in-order response routing
module mma_icb_arbiter
  import mma_icb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_MMA_REQ,
  parameter int ADDR_WIDTH  = ICB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = ICB_DATA_WIDTH,
  parameter int OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_cmd_valid,
  output logic [NUM_REQ-1:0]              req_cmd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_cmd_addr,
  input  logic [NUM_REQ-1:0]              req_cmd_read,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_cmd_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_cmd_wmask,
  output logic [NUM_REQ-1:0]              req_rsp_valid,
  input  logic [NUM_REQ-1:0]              req_rsp_ready,
  output logic [DATA_WIDTH-1:0]           req_rsp_rdata,
  output logic                            req_rsp_err,
  output logic                            m_cmd_valid,
  input  logic                            m_cmd_ready,
  output logic [ADDR_WIDTH-1:0]           m_cmd_addr,
  output logic                            m_cmd_read,
  output logic [DATA_WIDTH-1:0]           m_cmd_wdata,
  output logic [DATA_WIDTH/8-1:0]         m_cmd_wmask,
  input  logic                            m_rsp_valid,
  output logic                            m_rsp_ready,
  input  logic [DATA_WIDTH-1:0]           m_rsp_rdata,
  input  logic                            m_rsp_err,
  output logic                            busy,
  output logic                            err_unexpected_rsp
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(OUTSTANDING) + 1;
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_lock_vld;
  logic [ID_W-1:0]  r_lock_id;
  logic             r_err;
  logic [ID_W-1:0]  w_grant;
  logic [ID_W-1:0]  w_cand;
  logic             w_found;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [ID_W-1:0]  w_head;
  logic             w_cmd_valid;
  logic             w_cmd_fire;
  logic             w_rsp_fire;

  always_comb begin
    w_grant = r_rr_ptr;
    w_cand  = '0;
    w_found = 1'b0;
    if (r_lock_vld) begin
      w_grant = r_lock_id;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_found && req_cmd_valid[w_cand]) begin
          w_grant = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  // full is taken from registered count only: a same-cycle pop never frees a slot
  assign w_cmd_valid = rst_n & ~w_full & req_cmd_valid[w_grant];
  assign w_cmd_fire  = w_cmd_valid & m_cmd_ready;
  assign m_cmd_valid = w_cmd_valid;

  always_comb begin
    m_cmd_addr    = '0;
    m_cmd_read    = 1'b0;
    m_cmd_wdata   = '0;
    m_cmd_wmask   = '0;
    req_cmd_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_grant) begin
        m_cmd_addr       = req_cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_cmd_read       = req_cmd_read[i];
        m_cmd_wdata      = req_cmd_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_cmd_wmask      = req_cmd_wmask[i*MASK_W +: MASK_W];
        req_cmd_ready[i] = rst_n & ~w_full & m_cmd_ready;
      end
    end
  end

  // With nothing outstanding the beat is swallowed and flagged
  always_comb begin
    req_rsp_valid = '0;
    m_rsp_ready   = 1'b0;
    if (rst_n) begin
      if (!w_empty) begin
        req_rsp_valid[w_head] = m_rsp_valid;
        m_rsp_ready           = req_rsp_ready[w_head];
      end else begin
        m_rsp_ready = 1'b1;
      end
    end
  end

  assign w_rsp_fire         = m_rsp_valid & m_rsp_ready & ~w_empty;
  assign req_rsp_rdata      = m_rsp_rdata;
  assign req_rsp_err        = m_rsp_err;
  assign busy               = (w_count != '0);
  assign err_unexpected_rsp = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_lock_vld <= 1'b0;
        r_rr_ptr   <= (w_grant == LAST_ID) ? '0 : w_grant + 1'b1;
      end else if (w_cmd_valid) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_grant;
      end
      if (m_rsp_valid && w_empty) r_err <= 1'b1;
    end
  end

  icb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .ID_W  (ID_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_cmd_fire),
    .i_push_id (w_grant),
    .i_pop     (w_rsp_fire),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_head    (w_head)
  );

endmodule

// File: tb/tb_mma_icb_arbiter.sv
// tb/tb_mma_icb_arbiter.sv - directed and randomized checks of mma_icb_arbiter against a queue model
module tb_mma_icb_arbiter;
  import mma_icb_pkg::*;

  localparam int N   = 5;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int OST = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_cmd_valid, req_cmd_ready, req_cmd_read;
  logic [N-1:0]    req_rsp_valid, req_rsp_ready;
  logic [N*AW-1:0] req_cmd_addr;
  logic [N*DW-1:0] req_cmd_wdata;
  logic [N*MW-1:0] req_cmd_wmask;
  logic [DW-1:0]   req_rsp_rdata, m_cmd_wdata, m_rsp_rdata;
  logic [AW-1:0]   m_cmd_addr;
  logic [MW-1:0]   m_cmd_wmask;
  logic            req_rsp_err, m_cmd_valid, m_cmd_ready, m_cmd_read;
  logic            m_rsp_valid, m_rsp_ready, m_rsp_err, busy, err_unexpected_rsp;

  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  logic [MW-1:0] wmask_a [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_cmd_addr[i*AW +: AW]  = addr_a[i];
    assign req_cmd_wdata[i*DW +: DW] = wdata_a[i];
    assign req_cmd_wmask[i*MW +: MW] = wmask_a[i];
  end

  mma_icb_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
    .req_cmd_addr(req_cmd_addr), .req_cmd_read(req_cmd_read),
    .req_cmd_wdata(req_cmd_wdata), .req_cmd_wmask(req_cmd_wmask),
    .req_rsp_valid(req_rsp_valid), .req_rsp_ready(req_rsp_ready),
    .req_rsp_rdata(req_rsp_rdata), .req_rsp_err(req_rsp_err),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_addr(m_cmd_addr), .m_cmd_read(m_cmd_read),
    .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
    .busy(busy), .err_unexpected_rsp(err_unexpected_rsp)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: who is owed a response, whose turn it is, and a pending (locked) grant
  int tagq[$];
  int m_rr = 0;
  bit m_lock = 1'b0;
  int m_lock_id = 0;
  bit m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_cmd_valid = '0;
    req_cmd_read  = '0;
    req_rsp_ready = '0;
    m_cmd_ready   = 1'b0;
    m_rsp_valid   = 1'b0;
    m_rsp_rdata   = '0;
    m_rsp_err     = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = AW'(32'h100 * i);
      wdata_a[i] = DW'(32'h5A00 + i);
      wmask_a[i] = 4'hF;
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    m_rr = 0;
    m_lock = 1'b0;
    m_lock_id = 0;
    m_err = 1'b0;
  endtask

  // Compare every output against the model, advance the model, then move to the next cycle
  task automatic cyc();
    int g;
    int h;
    bit full;
    bit v;
    bit pop;
    logic [N-1:0] exp_rdy;
    full = (tagq.size() == OST);
    g = -1;
    if (m_lock) g = m_lock_id;
    else
      for (int k = 0; k < N; k++)
        if (g < 0 && req_cmd_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
    v = 1'b0;
    if (g >= 0) v = !full && req_cmd_valid[g];
    exp_rdy = '0;
    if (v && m_cmd_ready) exp_rdy[g] = 1'b1;
    chk("m_cmd_valid", m_cmd_valid, v);
    chk("req_cmd_ready", req_cmd_ready & req_cmd_valid, exp_rdy);
    if (v) begin
      chk("m_cmd_addr", m_cmd_addr, addr_a[g]);
      chk("m_cmd_payload", {m_cmd_read, m_cmd_wmask, m_cmd_wdata}, {req_cmd_read[g], wmask_a[g], wdata_a[g]});
    end
    h = (tagq.size() > 0) ? tagq[0] : 0;
    if (tagq.size() > 0) begin
      chk("req_rsp_valid", req_rsp_valid, m_rsp_valid ? (N'(1) << h) : N'(0));
      chk("m_rsp_ready", m_rsp_ready, req_rsp_ready[h]);
    end else begin
      chk("req_rsp_valid_empty", req_rsp_valid, 0);
      chk("m_rsp_ready_empty", m_rsp_ready, 1);
    end
    chk("rsp_payload", {req_rsp_err, req_rsp_rdata}, {m_rsp_err, m_rsp_rdata});
    chk("busy", busy, tagq.size() != 0);
    chk("err_unexpected_rsp", err_unexpected_rsp, m_err);
    pop = (tagq.size() > 0) && m_rsp_valid && req_rsp_ready[h];
    if (tagq.size() == 0 && m_rsp_valid) m_err = 1'b1;
    if (pop) void'(tagq.pop_front());
    if (v && m_cmd_ready) begin
      tagq.push_back(g);
      m_rr = (g + 1) % N;
      m_lock = 1'b0;
    end else if (v) begin
      m_lock = 1'b1;
      m_lock_id = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #1;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", err_unexpected_rsp, 0);
    chk("rst_m_rsp_ready", m_rsp_ready, 0);
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_err", err_unexpected_rsp, 0);
    req_cmd_valid = '1;
    m_cmd_ready   = 1'b1;
    m_rsp_valid   = 1'b1;
    req_rsp_ready = '1;
    #1;
    chk("reset_m_cmd_valid", m_cmd_valid, 0);
    chk("reset_req_cmd_ready", req_cmd_ready, 0);
    chk("reset_m_rsp_ready", m_rsp_ready, 0);
    chk("reset_req_rsp_valid", req_rsp_valid, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Single IA read, no contention
    req_cmd_valid = N'(1) << REQ_IA;
    addr_a[REQ_IA] = 32'h1000;
    req_cmd_read[REQ_IA] = 1'b1;
    m_cmd_ready = 1'b1;
    #1;
    chk("ia_addr", m_cmd_addr, 32'h1000);
    chk("ia_ready", req_cmd_ready, 5'b00100);
    cyc();
    req_cmd_valid = '0;
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'hDEADBEEF;
    req_rsp_ready = '1;
    #1;
    chk("ia_busy", busy, 1);
    chk("ia_rsp_valid", req_rsp_valid, 5'b00100);
    chk("ia_rdata", req_rsp_rdata, 32'hDEADBEEF);
    cyc();
    m_rsp_valid = 1'b0;
    #1;
    chk("ia_busy_after", busy, 0);
    cyc();

    // Round-robin with all requesters valid; one response per cycle keeps the FIFO shallow
    do_reset();
    req_cmd_valid = '1;
    m_cmd_ready = 1'b1;
    req_rsp_ready = '1;
    for (int i = 0; i < 10; i++) begin
      m_rsp_valid = (i > 0);
      #1;
      chk($sformatf("rr_grant%0d", i), req_cmd_ready, N'(1) << (i % N));
      cyc();
    end
    req_cmd_valid = '0;
    m_rsp_valid = 1'b1;
    step();
    m_rsp_valid = 1'b0;

    // Grant lock: weight stalled three cycles while bias waits
    req_cmd_valid = 5'b00011;
    addr_a[REQ_WEIGHT] = 32'hA000;
    addr_a[REQ_BIAS] = 32'hB000;
    m_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_valid", m_cmd_valid, 1);
      chk("lock_addr", m_cmd_addr, 32'hA000);
      cyc();
    end
    m_cmd_ready = 1'b1;
    #1;
    chk("lock_accept", req_cmd_ready, 5'b00001);
    cyc();
    req_cmd_valid = 5'b00010;
    #1;
    chk("lock_bias_next", req_cmd_ready, 5'b00010);
    chk("lock_bias_addr", m_cmd_addr, 32'hB000);
    cyc();
    // rr now points at IA; a locked DST must win over a newly arriving IA
    req_cmd_valid = 5'b10000;
    addr_a[REQ_DST] = 32'hD000;
    addr_a[REQ_IA] = 32'hC000;
    m_cmd_ready = 1'b0;
    step();
    req_cmd_valid = 5'b10100;
    #1;
    chk("lock_hold_addr", m_cmd_addr, 32'hD000);
    cyc();
    m_cmd_ready = 1'b1;
    #1;
    chk("lock_hold_ready", req_cmd_ready, 5'b10000);
    cyc();
    req_cmd_valid = '0;
    m_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    m_rsp_valid = 1'b0;

    // Outstanding limit
    req_cmd_valid = 5'b00001;
    for (int i = 0; i < OST; i++) step();
    #1;
    chk("full_cmd_valid", m_cmd_valid, 0);
    chk("full_cmd_ready", req_cmd_ready, 0);
    cyc();
    m_rsp_valid = 1'b1;
    #1;
    chk("full_pop_still_blocked", m_cmd_valid, 0);
    cyc();
    m_rsp_valid = 1'b0;
    #1;
    chk("full_released", req_cmd_ready, 5'b00001);
    cyc();
    req_cmd_valid = '0;
    m_rsp_valid = 1'b1;
    for (int i = 0; i < OST; i++) step();
    m_rsp_valid = 1'b0;

    // Response routing under backpressure: issue IA, DST, BIAS
    req_cmd_valid = N'(1) << REQ_IA;  step();
    req_cmd_valid = N'(1) << REQ_DST; step();
    req_cmd_valid = N'(1) << REQ_BIAS; step();
    req_cmd_valid = '0;
    m_rsp_valid = 1'b1;
    req_rsp_ready = 5'b01111;
    #1;
    chk("bp_rsp_ia", req_rsp_valid, 5'b00100);
    cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_rsp_dst_held", req_rsp_valid, 5'b10000);
      chk("bp_m_rsp_ready", m_rsp_ready, 0);
      cyc();
    end
    req_rsp_ready = '1;
    #1;
    chk("bp_rsp_dst", req_rsp_valid, 5'b10000);
    cyc();
    #1;
    chk("bp_rsp_bias", req_rsp_valid, 5'b00010);
    cyc();
    m_rsp_valid = 1'b0;

    // Spurious response, then reset with commands in flight
    m_rsp_valid = 1'b1;
    req_rsp_ready = '0;
    #1;
    chk("spur_ready", m_rsp_ready, 1);
    chk("spur_no_valid", req_rsp_valid, 0);
    cyc();
    m_rsp_valid = 1'b0;
    #1;
    chk("spur_flag", err_unexpected_rsp, 1);
    cyc();
    req_cmd_valid = 5'b01000;
    step();
    step();
    req_cmd_valid = '0;
    #1;
    chk("pre_reset_busy", busy, 1);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      req_cmd_valid = N'($urandom);
      req_cmd_read  = N'($urandom);
      m_cmd_ready   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        addr_a[i]  = $urandom;
        wdata_a[i] = $urandom;
        wmask_a[i] = MW'($urandom);
      end
      m_rsp_valid   = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
      req_rsp_ready = N'($urandom);
      m_rsp_rdata   = $urandom;
      m_rsp_err     = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
